hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 73 +++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: forwarding selects, load-use/long-op stall and pending-register scoreboard.
// Define HAZARD_STALL_STATS_EN to add the saturating Stall_Count output.
module hazard_scoreboard #(
  parameter int NUM_RS = 2,
  parameter int AW = 5,
  parameter int MAX_PEND = 4,
  localparam int NR = 2**AW,
  localparam int CW = $clog2(MAX_PEND+1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_RS*AW-1:0] Rs_ID,
  input  logic [NUM_RS-1:0]    Rs_Used_ID,
  input  logic [AW-1:0]        Rd_ID,
  input  logic                 Long_ID,
  input  logic                 Flush,
  input  logic [AW-1:0]        Rd_IDEX,
  input  logic                 IDEX_MemRead,
  input  logic                 EX_MEM_RegWEN,
  input  logic [AW-1:0]        Rd_EX,
  input  logic                 MEM_WB_RegWEN,
  input  logic [AW-1:0]        Rd_MA,
  input  logic                 Long_Done,
  input  logic [AW-1:0]        Long_Done_Rd,
  output logic [NUM_RS*2-1:0]  Fw,
  output logic                 Fw_Dectected,
  output logic                 Stall,
  output logic [NR-1:0]        Pending,
  output logic [CW-1:0]        Pend_Count
`ifdef HAZARD_STALL_STATS_EN
  ,output logic [31:0]         Stall_Count
`endif
);
  logic load_use, raw, waw, full, issue, done;
  logic [NR-1:0] set_v, clr_v;
  always_comb begin
    Fw = '0;
    load_use = 1'b0;
    raw = 1'b0;
    for (int k = 0; k < NUM_RS; k++) begin
      if (Rs_Used_ID[k]) begin
        Fw[2*k +: 2] = (EX_MEM_RegWEN && Rd_EX != '0 && Rd_EX == Rs_ID[k*AW +: AW]) ? 2'b10 :
                       (MEM_WB_RegWEN && Rd_MA != '0 && Rd_MA == Rs_ID[k*AW +: AW]) ? 2'b01 : 2'b00;
        load_use |= IDEX_MemRead && Rd_IDEX != '0 && Rd_IDEX == Rs_ID[k*AW +: AW];
        raw |= Rs_ID[k*AW +: AW] != '0 && Pending[Rs_ID[k*AW +: AW]];
      end
    end
  end
  assign Fw_Dectected = |Fw;
  assign waw = Long_ID && Rd_ID != '0 && Pending[Rd_ID];
  assign full = Long_ID && Rd_ID != '0 && Pend_Count == CW'(MAX_PEND);
  assign Stall = ~Flush & (load_use | raw | waw | full);
  assign issue = Long_ID & ~Stall & ~Flush & (Rd_ID != '0);
  // Pending[0] is never set, so a completion tagged x0 is dropped here too
  assign done = Long_Done & Pending[Long_Done_Rd];
  assign set_v = NR'(issue) << Rd_ID;
  assign clr_v = NR'(done) << Long_Done_Rd;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Pending <= '0;
      Pend_Count <= '0;
    end else begin
      Pending <= ((Pending & ~clr_v) | set_v) & ~NR'(1);
      Pend_Count <= Pend_Count + CW'(issue) - CW'(done);
    end
  end
`ifdef HAZARD_STALL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) Stall_Count <= '0;
    else if (Stall && Stall_Count != '1) Stall_Count <= Stall_Count + 32'd1;
  end
`endif
endmodule
